// File: rtl/if_id_pkg.sv
// Shared types for the IF->ID immediate stage: format codes, opcodes, entry payloads.
// Optional IMM_SEXT_EN build adds a final 32-bit immediate computed with imm_final().
package if_id_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IMM_RAW_W = 21;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_BAD = 3'd7
  } imm_fmt_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    imm_fmt_t               fmt;
    logic [IMM_RAW_W-1:0]   imm_raw;
    logic                   illegal;
  } imm_dec_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    imm_dec_t        dec;
  } if_id_entry_t;

  // Widen a raw immediate the way the downstream extender does (U is pre-shifted).
  function automatic logic [XLEN-1:0] imm_final(imm_fmt_t fmt, logic [IMM_RAW_W-1:0] raw);
    logic [XLEN-1:0] res;
    res = '0;
    case (fmt)
      FMT_I, FMT_S, FMT_B, FMT_J: res = {{(XLEN-IMM_RAW_W){raw[IMM_RAW_W-1]}}, raw};
      FMT_U:                      res = {raw[19:0], 12'b0};
      default:                    res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/if_id_imm_stage_imm_field_decode.sv
// Combinational opcode -> immediate format decode and raw immediate assembly.
module imm_field_decode
  import if_id_pkg::*;
(
  input  logic [31:0]          instr,
  output logic [2:0]           fmt,
  output logic [IMM_RAW_W-1:0] imm_raw,
  output logic                 illegal
);

  imm_fmt_t fmt_e;

  always_comb begin
    fmt_e = FMT_BAD;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt_e = FMT_I;
      OP_STORE:                            fmt_e = FMT_S;
      OP_BRANCH:                           fmt_e = FMT_B;
      OP_LUI, OP_AUIPC:                    fmt_e = FMT_U;
      OP_JAL:                              fmt_e = FMT_J;
      OP_REG:                              fmt_e = FMT_R;
      default:                             fmt_e = FMT_BAD;
    endcase
  end

  // Raw field is 21 bits; B/J carry an implicit zero LSB, U keeps its top bit duplicated.
  always_comb begin
    imm_raw = '0;
    case (fmt_e)
      FMT_I: imm_raw = {{9{instr[31]}}, instr[31:20]};
      FMT_S: imm_raw = {{9{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm_raw = {{8{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J: imm_raw = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U: imm_raw = {instr[31], instr[31:12]};
      default: imm_raw = '0;
    endcase
  end

  assign fmt     = fmt_e;
  assign illegal = (fmt_e == FMT_BAD);

endmodule

// File: rtl/if_id_imm_stage.sv
// IF->ID stage with 2-entry skid buffer; stores pre-decoded immediate fields.
// Define IMM_SEXT_EN to add the registered 32-bit out_imm port.
module if_id_imm_stage
  import if_id_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [31:0]          in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_pc,
  output logic [2:0]           out_fmt,
  output logic [IMM_RAW_W-1:0] out_imm_raw,
  output logic                 out_illegal
`ifdef IMM_SEXT_EN
  ,
  output logic [XLEN-1:0]      out_imm
`endif
);

  logic [2:0]           dec_fmt;
  logic [IMM_RAW_W-1:0] dec_raw;
  logic                 dec_illegal;
  if_id_entry_t         in_entry;

  if_id_entry_t main_q, main_d, skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_fire, out_fire;

  imm_field_decode u_dec (
    .instr   (in_instr),
    .fmt     (dec_fmt),
    .imm_raw (dec_raw),
    .illegal (dec_illegal)
  );

  always_comb begin
    in_entry.instr       = in_instr;
    in_entry.pc          = in_pc;
    in_entry.dec.fmt     = imm_fmt_t'(dec_fmt);
    in_entry.dec.imm_raw = dec_raw;
    in_entry.dec.illegal = dec_illegal;
  end

  // Next-state: skid drains first to keep FIFO order; new input bypasses skid when main frees.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    in_fire      = in_valid & in_ready_q;
    out_fire     = out_valid_q & out_ready;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_fire) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q || out_fire) begin
        main_d      = in_entry;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

`ifdef IMM_SEXT_EN
  logic [XLEN-1:0] imm_q;

  always_ff @(posedge clk) begin
    if (rst) imm_q <= '0;
    else     imm_q <= imm_final(main_d.dec.fmt, main_d.dec.imm_raw);
  end

  assign out_imm = imm_q;
`endif

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = main_q.instr;
  assign out_pc      = main_q.pc;
  assign out_fmt     = main_q.dec.fmt;
  assign out_imm_raw = main_q.dec.imm_raw;
  assign out_illegal = main_q.dec.illegal;

endmodule

// File: doc/if_id_imm_stage.md
Name: if_id_imm_stage

Overview:
- IF→ID pipeline stage with a registered valid/ready interface, placed directly upstream of the immediate sign extender.
- Captures each fetched instruction and its PC, decodes the immediate format from the opcode, and assembles the 21-bit raw immediate that the extender widens to 32 bits.
- A 2-entry skid buffer decouples fetch backpressure from decode.

Parameters:
XLEN, 32, instruction/PC width
IMM_RAW_W, 21, raw immediate width handed to the extender

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous pipeline flush (branch/jump redirect)
in_valid  in  1  fetch holds a valid instruction
in_ready  out  1  stage can accept an instruction
in_instr  in  32  fetched instruction
in_pc  in  32  PC of in_instr
out_valid  out  1  decoded entry available
out_ready  in  1  downstream accepts the entry
out_instr  out  32  registered instruction
out_pc  out  32  registered PC
out_fmt  out  3  immediate format code (package enum)
out_imm_raw  out  21  raw immediate to the extender
out_illegal  out  1  opcode not recognised

Behaviour:
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Latency: 1 cycle from input acceptance to out_valid.
- Storage: main register (drives outputs) plus skid register.
  - Input accepted while main is full and not draining → goes to skid.
  - in_ready = !skid_valid, driven from a register (no combinational path from out_ready).
  - When main drains and skid is full, skid moves to main the same edge; FIFO order preserved.
- Format decode from in_instr[6:0], done before registering:
  - 0010011/0000011/1100111/1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111/0010111 → U
  - 1101111 → J
  - 0110011 → R
  - anything else → BAD, with out_illegal=1
- Raw immediate (i = instruction):
  - I: sext9(i[31]),i[31:20]
  - S: sext9(i[31]),i[31:25],i[11:7]
  - B: sext8(i[31]),i[31],i[7],i[30:25],i[11:8],0
  - J: i[31],i[19:12],i[20],i[30:21],0
  - U: i[31],i[31:12]; the consumer shifts this left by 12 after extension
  - R/BAD: 0
- Reset (rst high at an edge): out_valid=0, skid_valid=0, in_ready=1, out_instr=0, out_pc=0, out_fmt=R(0), out_imm_raw=0, out_illegal=0.
  - No transfers occur while rst is high, whatever in_valid is.
- Flush: same edge effect on the valid flags as reset. Data registers may hold stale values; out_valid=0 masks them.
  - An input offered in the flush cycle is dropped.
  - in_ready=1 the following cycle.
- rst and flush together: reset wins (identical result).
- Simultaneous input accept and output drain with main full and skid empty: new entry loads main directly and skid stays empty (full throughput).
- out_valid=1 and out_ready=0: all out_* signals stay stable until transfer.

Optional Feature:
IMM_SEXT_EN
- Defined: adds output port out_imm [31:0], registered with main, holding the final 32-bit immediate.
  - I/S/B/J: out_imm = sign-extension of out_imm_raw.
  - U: out_imm = i[31:12],12'b0.
  - R/BAD: out_imm = 0.
  - Reset value 0.
  - Lets decode bypass the external extender.
- Undefined: port absent; only out_imm_raw is produced.

Decomposition:
- Package if_id_pkg:
  - imm_fmt_t enum: R=0, I=1, S=2, B=3, U=4, J=5, BAD=7
  - opcode localparams
  - IMM_RAW_W constant
- One natural sub-module: imm_field_decode (combinational: instr → fmt, raw, illegal). It is instantiated once, ahead of the skid logic, so both registers store decoded fields.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 → one cycle later out_valid=1, fmt=I, raw=0x1FFFFF, illegal=0; out_imm=0xFFFFFFFF if IMM_SEXT_EN.
- 0x123452B7 (lui) → fmt=U, raw=0x012345; 0x00000463 (beq +8) → fmt=B, raw=0x000008; 0xFFDFF06F (jal -4) → fmt=J, raw=0x1FFFFC.
- out_ready=0, feed PCs 0x0,0x4,0x8 back-to-back:
  - in_ready drops after 0x4 is accepted; 0x8 is held at the input.
  - Then raise out_ready: outputs 0x0,0x4,0x8 in order, no loss or duplication.
- Main and skid both full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; the flush-cycle input never appears.
- 0x0000007F → fmt=BAD(7), illegal=1, raw=0.
- Assert rst mid-stream with in_valid=1 → next cycle out_valid=0, in_ready=1, all outputs 0; the first post-reset instruction emerges one cycle after acceptance.
